// File: rtl/mult_div_seq.sv
// Sequential signed/unsigned multiply and restoring divide for the HI/LO datapath.
// One bit per clock: start accepted at edge N, done pulses after edge N+WIDTH+1.
module mult_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   count;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               b_zero;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  // op[0]=0 selects the signed variants; MIN keeps its bit pattern as an unsigned magnitude.
  assign a_neg     = ~op[0] & a[WIDTH-1];
  assign b_neg     = ~op[0] & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Multiply: acc_hi accumulates, acc_lo holds the multiplier and shifts in low product bits.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign rem_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = rem_shift >= {1'b0, operand};
  assign div_rem   = WIDTH'(rem_shift - {1'b0, operand});

  assign prod      = {acc_hi, acc_lo};
  assign prod_neg  = -prod;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      b_zero   <= 1'b0;
      a_raw    <= '0;
      operand  <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_raw    <= a;
            is_div   <= op[1];
            operand  <= op[1] ? b_mag : a_mag;
            acc_hi   <= '0;
            acc_lo   <= op[1] ? a_mag : b_mag;
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= op[1] ? a_neg : (a_neg ^ b_neg);
            b_zero   <= op[1] & (b == '0);
            div_zero <= 1'b0;
            busy     <= 1'b1;
            count    <= '0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          done <= 1'b0;
          if (is_div) begin
            if (div_ge) begin
              acc_hi <= div_rem;
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= rem_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            state <= S_FINISH;
          end
        end
        S_FINISH: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= b_zero;
          state    <= S_IDLE;
          if (is_div) begin
            if (b_zero) begin
              lo <= '1;
              hi <= a_raw;
            end else begin
              lo <= neg_lo ? -acc_lo : acc_lo;
              hi <= neg_hi ? -acc_hi : acc_hi;
            end
          end else begin
            {hi, lo} <= neg_lo ? prod_neg : prod;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed-vector bench for mult_div_seq at WIDTH=32 with hand-computed results.
module tb_mult_div_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  mult_div_seq #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; launches one op and returns on the negedge where done is seen.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit inject);
    int edges;
    int busy_cnt;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
    check({tag, "_dz_at_start"}, 64'(div_zero), 64'd0);
    check({tag, "_busy_at_start"}, 64'(busy), 64'd1);
    edges = 0;
    busy_cnt = 0;
    while (!done && edges < 100) begin
      if (busy) busy_cnt++;
      start = inject && (edges == 5 || edges == 20);
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(edges), 64'd33);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic check_result(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                              input logic edz);
    check({tag, "_hi"}, 64'(hi), 64'(ehi));
    check({tag, "_lo"}, 64'(lo), 64'(elo));
    check({tag, "_dz"}, 64'(div_zero), 64'(edz));
  endtask

  task automatic check_pulse_end(input string tag);
    @(posedge clock);
    @(negedge clock);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int seen_done;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0);
    check_result("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    check_pulse_end("mult_neg");

    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check_result("multu_max", 32'hFFFFFFFE, 32'h00000001, 1'b0);

    run_op("mult_m1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check_result("mult_m1", 32'h0, 32'h1, 1'b0);

    run_op("divu", OP_DIVU, 32'd100, 32'd7, 1'b0);
    check_result("divu", 32'd2, 32'd14, 1'b0);

    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    check_result("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);

    run_op("div_negb", OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b0);
    check_result("div_negb", 32'd1, 32'hFFFFFFFD, 1'b0);

    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check_result("div_ovf", 32'h0, 32'h80000000, 1'b0);

    run_op("div_zero", OP_DIV, 32'd5, 32'd0, 1'b0);
    check_result("div_zero", 32'd5, 32'hFFFFFFFF, 1'b1);

    run_op("after_dz", OP_MULT, 32'd2, 32'd3, 1'b0);
    check_result("after_dz", 32'd0, 32'd6, 1'b0);

    run_op("div_zero_neg", OP_DIV, 32'hFFFFFFF9, 32'd0, 1'b0);
    check_result("div_zero_neg", 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);

    run_op("ignore_start", OP_MULTU, 32'h1234, 32'h10, 1'b1);
    check_result("ignore_start", 32'h0, 32'h12340, 1'b0);
    check_pulse_end("ignore_start");

    // Second start issued on the negedge where the first done is visible.
    run_op("b2b_first", OP_MULT, 32'h10000, 32'h10000, 1'b0);
    check_result("b2b_first", 32'h1, 32'h0, 1'b0);
    run_op("b2b_second", OP_DIVU, 32'hFFFFFFFF, 32'h10, 1'b0);
    check_result("b2b_second", 32'hF, 32'h0FFFFFFF, 1'b0);

    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) seen_done++;
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    for (int i = 0; i < 50; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) seen_done++;
    end
    check("rst_mid_no_done", 64'(seen_done), 64'd0);

    run_op("after_rst", OP_DIV, 32'hFFFFFF9C, 32'd7, 1'b0);
    check_result("after_rst", 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);
    check_pulse_end("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
